// File: rtl/dpram_hs_if.sv
// dpram_hs_if: request/response bundle shared by the two dpram_hs ports plus clear and status.
interface dpram_hs_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   localparam int BE_W = DATA_W / 8;
   logic              clr, busy, collision;
   logic              valid_a, ready_a, we_a, qvalid_a, qready_a;
   logic              valid_b, ready_b, we_b, qvalid_b, qready_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] data_a, data_b, q_a, q_b;
   logic [BE_W-1:0]   be_a, be_b;
   modport master (
      output clr, valid_a, we_a, addr_a, data_a, be_a, qready_a,
      output valid_b, we_b, addr_b, data_b, be_b, qready_b,
      input  busy, collision, ready_a, q_a, qvalid_a, ready_b, q_b, qvalid_b
   );
   modport slave (
      input  clr, valid_a, we_a, addr_a, data_a, be_a, qready_a,
      input  valid_b, we_b, addr_b, data_b, be_b, qready_b,
      output busy, collision, ready_a, q_a, qvalid_a, ready_b, q_b, qvalid_b
   );
endinterface

// File: rtl/dpram_hs.sv
// dpram_hs: true dual-port byte-enabled RAM with valid/ready requests, held read responses
// and a clear sequencer that zeroes the array after reset or on request.
module dpram_hs #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter bit PRI_B  = 1'b0
) (
   input  logic      clk,
   input  logic      rst_n,
   dpram_hs_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, IDLE} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
   logic              qvalid_a_q, qvalid_a_d, qvalid_b_q, qvalid_b_d;
   logic              collision_q, collision_d;
   logic              rdy_a, rdy_b, acc_a, acc_b, rd_a, rd_b;
   logic [BE_W-1:0]   both, wr_a, wr_b;
   logic [DATA_W-1:0] mem [DEPTH];
   assign rdy_a         = state_q == IDLE && (!qvalid_a_q || bus.qready_a);
   assign rdy_b         = state_q == IDLE && (!qvalid_b_q || bus.qready_b);
   assign acc_a         = bus.valid_a && rdy_a;
   assign acc_b         = bus.valid_b && rdy_b;
   assign rd_a          = acc_a && !bus.we_a;
   assign rd_b          = acc_b && !bus.we_b;
   assign bus.ready_a   = rdy_a;
   assign bus.ready_b   = rdy_b;
   assign bus.busy      = state_q == CLEAR;
   assign bus.collision = collision_q;
   assign bus.q_a       = q_a_q;
   assign bus.q_b       = q_b_q;
   assign bus.qvalid_a  = qvalid_a_q;
   assign bus.qvalid_b  = qvalid_b_q;
   // Lanes written by both ports go to the winner only; the loser's lane write is masked.
   always_comb begin
      both        = {BE_W{acc_a && acc_b && bus.we_a && bus.we_b && bus.addr_a == bus.addr_b}}
                    & bus.be_a & bus.be_b;
      wr_a        = {BE_W{acc_a && bus.we_a}} & bus.be_a & ~(both & {BE_W{PRI_B}});
      wr_b        = {BE_W{acc_b && bus.we_b}} & bus.be_b & ~(both & {BE_W{!PRI_B}});
      collision_d = |both;
      q_a_d       = rd_a ? mem[bus.addr_a] : q_a_q;
      q_b_d       = rd_b ? mem[bus.addr_b] : q_b_q;
      qvalid_a_d  = rd_a || (qvalid_a_q && !bus.qready_a);
      qvalid_b_d  = rd_b || (qvalid_b_q && !bus.qready_b);
      state_d     = bus.clr ? CLEAR : (state_q == CLEAR && &clr_addr_q) ? IDLE : state_q;
      clr_addr_d  = (bus.clr || state_q != CLEAR) ? '0 : clr_addr_q + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         clr_addr_q  <= '0;
         q_a_q       <= '0;
         q_b_q       <= '0;
         qvalid_a_q  <= 1'b0;
         qvalid_b_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         q_a_q       <= q_a_d;
         q_b_q       <= q_b_d;
         qvalid_a_q  <= qvalid_a_d;
         qvalid_b_q  <= qvalid_b_d;
         collision_q <= collision_d;
      end
   end
   // Storage is deliberately not reset; the clear sequence provides known contents.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) mem[clr_addr_q] <= '0;
      for (int i = 0; i < BE_W; i++) begin
         if (wr_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.data_a[8*i +: 8];
         if (wr_b[i]) mem[bus.addr_b][8*i +: 8] <= bus.data_b[8*i +: 8];
      end
   end
endmodule
